// File: rtl/fu_scheduler_pkg.sv
// Shared types for the issue-select stage.
// Reservation-station output and FU issue packet layouts.
package fu_scheduler_pkg;

    localparam int NUM_RS   = 4;
    localparam int DATA_W   = 32;
    localparam int RS_IDX_W = 2;

    typedef struct packed {
        logic              valid_operands;
        logic [2:0]        ALU_op;
        logic [3:0]        ROB_entry;
        logic [1:0]        branch_type;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
    } rs_out_t;

    typedef struct packed {
        logic [2:0]          ALU_op;
        logic [3:0]          ROB_entry;
        logic [1:0]          branch_type;
        logic [DATA_W-1:0]   rs1;
        logic [DATA_W-1:0]   rs2;
        logic [RS_IDX_W-1:0] rs_idx;
    } fu_issue_t;

    function automatic fu_issue_t to_issue(
        input rs_out_t             e,
        input logic [RS_IDX_W-1:0] idx
    );
        fu_issue_t p;
        p.ALU_op      = e.ALU_op;
        p.ROB_entry   = e.ROB_entry;
        p.branch_type = e.branch_type;
        p.rs1         = e.rs1;
        p.rs2         = e.rs2;
        p.rs_idx      = idx;
        return p;
    endfunction

endpackage

// File: rtl/fu_scheduler_arb.sv
// rr_arbiter4: combinational 4-way round-robin pick.
// Ports: req, ptr (first index searched) -> gnt one-hot, gnt_idx, any_gnt.
module rr_arbiter4
    import fu_scheduler_pkg::*;
(
    input  logic [NUM_RS-1:0]   req,
    input  logic [RS_IDX_W-1:0] ptr,
    output logic [NUM_RS-1:0]   gnt,
    output logic [RS_IDX_W-1:0] gnt_idx,
    output logic                any_gnt
);

    logic [RS_IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = '0;
        // Search ptr, ptr+1, ... wrapping; first requester wins.
        for (int k = 0; k < NUM_RS; k++) begin
            cand = ptr + RS_IDX_W'(k);
            if (!any_gnt && req[cand]) begin
                any_gnt = 1'b1;
                gnt_idx = cand;
            end
        end
        if (any_gnt) begin
            gnt = NUM_RS'(1) << gnt_idx;
        end
    end

endmodule

// File: rtl/fu_scheduler.sv
// Issue select: round-robin pick of a ready RS into a 1-entry FU register.
// Ports: busy_bus/rsN_data in, consumed_bus pulse out, issue_valid/issue_pkt to FU.
module fu_scheduler
    import fu_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mispredicted,
    input  logic [NUM_RS-1:0] busy_bus,
    input  rs_out_t           rs0_data,
    input  rs_out_t           rs1_data,
    input  rs_out_t           rs2_data,
    input  rs_out_t           rs3_data,
    input  logic              fu_ready,
    output logic [NUM_RS-1:0] consumed_bus,
    output logic              issue_valid,
    output fu_issue_t         issue_pkt
);

    rs_out_t             rs_all [NUM_RS];
    logic [NUM_RS-1:0]   settled;
    logic [NUM_RS-1:0]   eligible;
    logic [NUM_RS-1:0]   gnt;
    logic [RS_IDX_W-1:0] gnt_idx;
    logic [RS_IDX_W-1:0] ptr;
    logic                any_gnt;
    logic                can_accept;
    logic                grant;

    assign rs_all[0] = rs0_data;
    assign rs_all[1] = rs1_data;
    assign rs_all[2] = rs2_data;
    assign rs_all[3] = rs3_data;

    // valid_operands lags dispatch by a cycle, so an entry is only
    // trusted once it has been busy (and not consumed) for one edge.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            eligible[i] = busy_bus[i] & settled[i]
                        & rs_all[i].valid_operands;
        end
    end

    rr_arbiter4 u_arb (
        .req     (eligible),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign can_accept   = ~issue_valid | fu_ready;
    assign grant        = any_gnt & can_accept
                        & ~mispredicted & ~reset;
    assign consumed_bus = grant ? gnt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            settled     <= '0;
            ptr         <= '0;
            issue_valid <= 1'b0;
            issue_pkt   <= '0;
        end else if (mispredicted) begin
            // Packet is dropped even if the FU was ready.
            settled     <= '0;
            issue_valid <= 1'b0;
        end else begin
            settled <= busy_bus & ~consumed_bus;
            if (grant) begin
                issue_pkt   <= to_issue(rs_all[gnt_idx], gnt_idx);
                issue_valid <= 1'b1;
                ptr         <= gnt_idx + RS_IDX_W'(1);
            end else if (fu_ready) begin
                issue_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fu_scheduler.sv
// Directed scoreboard bench for fu_scheduler.
// Driver queues per-cycle expectations; a negedge monitor pops and compares.
module tb_fu_scheduler;
    import fu_scheduler_pkg::*;

    typedef struct {
        logic [3:0] cons;
        logic       ev;
        logic [1:0] idx;
        logic       ez;
    } exp_t;

    logic      clk = 1'b0;
    logic      reset;
    logic      mispredicted;
    logic      fu_ready;
    logic [3:0] busy_bus;
    rs_out_t   rs_d  [4];
    rs_out_t   rs_tb [4];
    logic [3:0] consumed_bus;
    logic      issue_valid;
    fu_issue_t issue_pkt;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fu_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .mispredicted (mispredicted),
        .busy_bus     (busy_bus),
        .rs0_data     (rs_d[0]),
        .rs1_data     (rs_d[1]),
        .rs2_data     (rs_d[2]),
        .rs3_data     (rs_d[3]),
        .fu_ready     (fu_ready),
        .consumed_bus (consumed_bus),
        .issue_valid  (issue_valid),
        .issue_pkt    (issue_pkt)
    );

    function automatic fu_issue_t mk(input logic [1:0] i);
        fu_issue_t p;
        p.ALU_op      = rs_tb[i].ALU_op;
        p.ROB_entry   = rs_tb[i].ROB_entry;
        p.branch_type = rs_tb[i].branch_type;
        p.rs1         = rs_tb[i].rs1;
        p.rs2         = rs_tb[i].rs2;
        p.rs_idx      = i;
        return p;
    endfunction

    task automatic chk(input string nm,
                       input logic [79:0] act,
                       input logic [79:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h",
                     nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("consumed_bus", 80'(consumed_bus), 80'(e.cons));
            chk("issue_valid", 80'(issue_valid), 80'(e.ev));
            if (e.ev)
                chk("issue_pkt", 80'(issue_pkt), 80'(mk(e.idx)));
            if (e.ez)
                chk("pkt_zero", 80'(issue_pkt), 80'(0));
        end
    end

    task automatic drive(
        input logic       rst, mp, fr,
        input logic [3:0] busy, vo, ecn,
        input logic       ev,
        input logic [1:0] eidx,
        input logic       ez
    );
        exp_t e;
        reset        = rst;
        mispredicted = mp;
        fu_ready     = fr;
        busy_bus     = busy;
        for (int i = 0; i < 4; i++) begin
            rs_d[i] = rs_tb[i];
            rs_d[i].valid_operands = vo[i];
        end
        e.cons = ecn;
        e.ev   = ev;
        e.idx  = eidx;
        e.ez   = ez;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rs_tb[0] = '{1'b0, 3'b001, 4'd1, 2'd1, 32'hA0, 32'hB0};
        rs_tb[1] = '{1'b0, 3'b011, 4'd9, 2'd2, 32'hA1, 32'hB1};
        rs_tb[2] = '{1'b0, 3'b010, 4'd5, 2'd0, 32'h10, 32'h20};
        rs_tb[3] = '{1'b0, 3'b111, 4'd14, 2'd3, 32'hA3, 32'hB3};
        reset        = 1'b1;
        mispredicted = 1'b0;
        fu_ready     = 1'b0;
        busy_bus     = '0;
        for (int i = 0; i < 4; i++) rs_d[i] = rs_tb[i];
        repeat (2) @(posedge clk);
        #1;

        // reset state
        drive(1,0,0, 4'b0000,4'b0000, 4'b0000, 0,0, 1);
        drive(1,0,0, 4'b0000,4'b0000, 4'b0000, 0,0, 1);
        // single issue from RS2 (busy first cycle not settled)
        drive(0,0,1, 4'b0100,4'b0100, 4'b0000, 0,0, 0);
        drive(0,0,1, 4'b0100,4'b0100, 4'b0100, 0,0, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 1,2, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 0,0, 0);
        // all eligible, ptr=3 after RS2 grant -> 3,0,1,2
        drive(0,0,1, 4'b1111,4'b1111, 4'b0000, 0,0, 0);
        drive(0,0,1, 4'b1111,4'b1111, 4'b1000, 0,0, 0);
        drive(0,0,1, 4'b0111,4'b0111, 4'b0001, 1,3, 0);
        drive(0,0,1, 4'b0110,4'b0110, 4'b0010, 1,0, 0);
        drive(0,0,1, 4'b0100,4'b0100, 4'b0100, 1,1, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 1,2, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 0,0, 0);
        // reset, then round-robin from ptr=0 -> 0,1,2,3
        drive(1,0,1, 4'b0000,4'b0000, 4'b0000, 0,0, 0);
        drive(0,0,1, 4'b1111,4'b1111, 4'b0000, 0,0, 1);
        drive(0,0,1, 4'b1111,4'b1111, 4'b0001, 0,0, 0);
        drive(0,0,1, 4'b1110,4'b1110, 4'b0010, 1,0, 0);
        drive(0,0,1, 4'b1100,4'b1100, 4'b0100, 1,1, 0);
        drive(0,0,1, 4'b1000,4'b1000, 4'b1000, 1,2, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 1,3, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 0,0, 0);
        // stale-valid guard, ptr wrapped to 0 so RS0 before RS1
        drive(0,0,1, 4'b0011,4'b0011, 4'b0000, 0,0, 0);
        drive(0,0,1, 4'b0011,4'b0011, 4'b0001, 0,0, 0);
        drive(0,0,1, 4'b0010,4'b0010, 4'b0010, 1,0, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 1,1, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 0,0, 0);
        // backpressure: RS3 packet held 3 cycles, RS0 waits
        drive(0,0,1, 4'b1001,4'b1001, 4'b0000, 0,0, 0);
        drive(0,0,0, 4'b1001,4'b1001, 4'b1000, 0,0, 0);
        drive(0,0,0, 4'b0001,4'b0001, 4'b0000, 1,3, 0);
        drive(0,0,0, 4'b0001,4'b0001, 4'b0000, 1,3, 0);
        drive(0,0,0, 4'b0001,4'b0001, 4'b0000, 1,3, 0);
        drive(0,0,1, 4'b0001,4'b0001, 4'b0001, 1,3, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 1,0, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 0,0, 0);
        // mispredict with packet valid and RS3 eligible
        drive(0,0,1, 4'b1010,4'b1010, 4'b0000, 0,0, 0);
        drive(0,0,1, 4'b1010,4'b1010, 4'b0010, 0,0, 0);
        drive(0,1,1, 4'b1000,4'b1000, 4'b0000, 1,1, 0);
        drive(0,0,1, 4'b1000,4'b1000, 4'b0000, 0,0, 0);
        drive(0,0,1, 4'b1000,4'b1000, 4'b1000, 0,0, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 1,3, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 0,0, 0);
        // reset mid-handshake with ptr=2; ptr must return to 0
        drive(0,0,1, 4'b0010,4'b0010, 4'b0000, 0,0, 0);
        drive(0,0,1, 4'b0010,4'b0010, 4'b0010, 0,0, 0);
        drive(1,0,1, 4'b0000,4'b0000, 4'b0000, 1,1, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 0,0, 1);
        drive(0,0,1, 4'b0110,4'b0110, 4'b0000, 0,0, 1);
        drive(0,0,1, 4'b0110,4'b0110, 4'b0010, 0,0, 1);
        drive(0,0,1, 4'b0100,4'b0100, 4'b0100, 1,1, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 1,2, 0);
        drive(0,0,1, 4'b0000,4'b0000, 4'b0000, 0,0, 0);

        @(negedge clk);
        #1;
        chk("queue_drained", 80'(exp_q.size()), 80'(0));
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
